// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage core: boot window, load-use
// interlock, branch redirect, mul/div occupancy and memory wait states.
module pipe_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int BOOT_DELAY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_rs1_use,
    input  logic                id_rs2_use,
    input  logic [4:0]          ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_branch_taken,
    input  logic [PC_WIDTH-1:0] ex_branch_target,
    input  logic                ex_md_start,
    input  logic                md_done,
    input  logic                mem_stall_req,
    output logic                work_ena,
    output logic                pc_stall,
    output logic                if_id_stall,
    output logic                id_ex_stall,
    output logic                ex_mem_stall,
    output logic                mem_wb_stall,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                ex_mem_flush,
    output logic                pc_redirect,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic [31:0]         stall_cycles
);

    typedef enum logic [1:0] {BOOT, RUN, MD_WAIT} state_t;

    localparam logic [7:0] BOOT_LIMIT = 8'(BOOT_DELAY);

    state_t     state;
    state_t     next_state;
    logic [7:0] boot_cnt;
    logic       load_use;

    assign pc_target = ex_branch_target;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_use && (id_rs1 == ex_rd)) ||
                       (id_rs2_use && (id_rs2 == ex_rd)));

    // Stalls, flushes and redirect must act in the same cycle, so they are
    // decoded combinationally from the registered state and the live inputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        next_state   = state;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;

        if (state == BOOT) begin
            pc_stall = 1'b1;
            if (boot_cnt == BOOT_LIMIT) next_state = RUN;
        end else if (mem_stall_req) begin
            // Freeze everything; EX/ID contents are re-presented once memory is ready.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (state == MD_WAIT) begin
            if (md_done) begin
                next_state = RUN;
            end else begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
        end else if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
            // A single-cycle op (done in its first cycle) never leaves RUN.
            if (!md_done) begin
                next_state   = MD_WAIT;
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT;
            boot_cnt     <= 8'd0;
            work_ena     <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state    <= next_state;
            work_ena <= (next_state != BOOT);
            if (state == BOOT) boot_cnt <= boot_cnt + 8'd1;
            if (work_ena && pc_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by randomized
// traffic, all compared against a cycle-count/occupancy reference model.
module tb_pipe_ctrl;

    localparam int PC_WIDTH   = 32;
    localparam int BOOT_DELAY = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [4:0]          id_rs1, id_rs2, ex_rd;
    logic                id_rs1_use, id_rs2_use, ex_mem_read;
    logic                ex_branch_taken, ex_md_start, md_done, mem_stall_req;
    logic [PC_WIDTH-1:0] ex_branch_target;
    logic                work_ena, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic                mem_wb_stall, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect;
    logic [PC_WIDTH-1:0] pc_target;
    logic [31:0]         stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset release, mul/div occupancy, stall count.
    int      m_edges;
    bit      m_md_busy;
    longint  m_stall;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_WIDTH(PC_WIDTH), .BOOT_DELAY(BOOT_DELAY)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .ex_md_start(ex_md_start), .md_done(md_done),
        .mem_stall_req(mem_stall_req), .work_ena(work_ena), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .mem_wb_stall(mem_wb_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control vector: {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem flushes, redirect}
    function automatic logic [8:0] model_ctrl();
        bit hazard;
        hazard = ex_mem_read && ex_rd != 0 &&
                 ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
        if (m_edges <= BOOT_DELAY)            return 9'b10000_0000;
        if (mem_stall_req)                    return 9'b11111_0000;
        if (m_md_busy)                        return md_done ? 9'b0 : 9'b11100_0010;
        if (ex_branch_taken)                  return 9'b00000_1101;
        if (ex_md_start)                      return md_done ? 9'b0 : 9'b11100_0010;
        if (hazard)                           return 9'b11000_0100;
        return 9'b0;
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect};
    endfunction

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0; ex_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_md_start = 0; md_done = 0;
        mem_stall_req = 0; ex_branch_target = '0;
    endtask

    // Called just after a falling edge with inputs already applied: compare, then
    // advance the model across the next rising edge.
    task automatic step();
        logic [8:0] exp;
        bit         exp_we;
        assert (!(ex_branch_taken && ex_md_start));
        #1;
        exp    = model_ctrl();
        exp_we = (m_edges > BOOT_DELAY);
        check("ctrl", 64'(dut_ctrl()), 64'(exp));
        check("work_ena", 64'(work_ena), 64'(exp_we));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check("pc_target", 64'(pc_target), 64'(ex_branch_target));
        if (exp_we && !mem_stall_req) begin
            if (m_md_busy && md_done) m_md_busy = 0;
            else if (!m_md_busy && !ex_branch_taken && ex_md_start && !md_done) m_md_busy = 1;
        end
        if (exp_we && exp[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_edges < 1000) m_edges++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_work_ena", 64'(work_ena), 64'd0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rst_ctrl", 64'(dut_ctrl()), 64'(9'b10000_0000));
        m_edges = 0; m_md_busy = 0; m_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] sc0;
        idle_inputs();
        rst = 1'b0;
        m_edges = 0; m_md_busy = 0; m_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Boot window: BOOT_DELAY+1 cycles of BOOT, then RUN.
        for (int i = 0; i < BOOT_DELAY + 2; i++) step();
        check("boot_done", 64'(work_ena), 64'd1);

        // Load-use on rs2, then the same with ex_rd = x0.
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_use = 1;
        check("load_use_seen", 64'(m_edges > BOOT_DELAY), 64'd1);
        step();
        ex_rd = 0; id_rs2 = 0;
        step();
        idle_inputs(); step();

        // Taken branch.
        ex_branch_taken = 1; ex_branch_target = 32'h0000_0100;
        step();
        idle_inputs(); step();

        // 4-cycle mul/div.
        sc0 = stall_cycles;
        ex_md_start = 1; step();
        ex_md_start = 0; step(); step();
        md_done = 1; step();
        md_done = 0; step();
        check("md_stall_delta", 64'(stall_cycles - sc0), 64'd3);

        // Memory stall over MD_WAIT while md_done is already up.
        ex_md_start = 1; step();
        ex_md_start = 0; step();
        md_done = 1; mem_stall_req = 1; step(); step();
        mem_stall_req = 0; step();
        md_done = 0; ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_use = 1; step();
        idle_inputs();

        // Reset while in MD_WAIT.
        ex_md_start = 1; step();
        ex_md_start = 0;
        pulse_reset();
        for (int i = 0; i < BOOT_DELAY + 2; i++) step();

        // Randomized traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            ex_rd            = 5'($urandom_range(0, 3));
            id_rs1_use       = 1'($urandom);
            id_rs2_use       = 1'($urandom);
            ex_mem_read      = 1'($urandom);
            ex_branch_taken  = ($urandom_range(0, 7) == 0);
            ex_md_start      = !ex_branch_taken && ($urandom_range(0, 5) == 0);
            md_done          = ($urandom_range(0, 2) == 0);
            mem_stall_req    = ($urandom_range(0, 5) == 0);
            ex_branch_target = $urandom;
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It produces the stall, flush and work-enable controls consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences three things:

- the post-reset boot window;
- load-use interlocks, branch redirects and data-memory wait states;
- multi-cycle mul/div occupancy of EX.

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- PC_WIDTH, 32, width of program counter and branch target
- BOOT_DELAY, 4, cycles after reset release before work_ena rises (0..255)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source register indices of instruction in ID
- id_rs1_use, id_rs2_use  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_branch_target  in  PC_WIDTH  redirect address
- ex_md_start  in  1  EX holds a mul/div op in its first EX cycle
- md_done  in  1  mul/div result valid this cycle
- mem_stall_req  in  1  data memory not ready; MEM must hold
- work_ena  out  1  registered; 0 forces pipeline registers to NOP
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  out  1 each  hold register
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load NOP into register
- pc_redirect  out  1  load pc_target into PC
- pc_target  out  PC_WIDTH  equals ex_branch_target
- stall_cycles  out  32  saturating count of cycles with pc_stall=1 while work_ena=1

## Operation
- States:
  - BOOT: after reset.
  - RUN: normal operation.
  - MD_WAIT: mul/div in progress.
- BOOT:
  - 8-bit counter increments each cycle.
  - At count==BOOT_DELAY: go to RUN and set work_ena=1 on that edge.
  - Outputs in BOOT: pc_stall=1; all other stall, flush and redirect outputs 0.
- Combinational control, in RUN/MD_WAIT, in priority order:
  1. mem_stall_req=1:
     - All five stalls = 1; all flushes and pc_redirect = 0.
     - No state transition.
  2. MD_WAIT with md_done=0:
     - pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush = 1.
  3. MD_WAIT with md_done=1:
     - All outputs 0; next state RUN.
  4. RUN with ex_branch_taken=1:
     - pc_redirect, if_id_flush, id_ex_flush = 1.
     - ex_md_start is ignored (illegal combination; bench asserts it never occurs).
  5. RUN with ex_md_start=1:
     - Same outputs as rule 2; next state MD_WAIT.
     - If md_done=1 in the same cycle (single-cycle op), treat as rule 3 and stay in RUN.
  6. RUN load-use: ex_mem_read && ex_rd!=0 && ((id_rs1_use && id_rs1==ex_rd) || (id_rs2_use && id_rs2==ex_rd)):
     - pc_stall, if_id_stall = 1; id_ex_flush = 1 (bubble).
  7. Otherwise: all 0.
- pc_target = ex_branch_target at all times; it is meaningful only when pc_redirect=1.
- stall_cycles:
  - Increments on each clk edge where work_ena=1 and pc_stall=1.
  - Saturates at 32'hFFFF_FFFF.

## Timing
- Reset (rst=0), asynchronous:
  - State BOOT, boot counter 0, work_ena 0, stall_cycles 0.
  - Combinational outputs take their BOOT values: pc_stall=1, rest 0.
- Reset asserted mid-operation, including in MD_WAIT or under a mem stall, returns to BOOT immediately. No pending stall is remembered.
- With BOOT_DELAY=N, work_ena rises on the (N+1)th rising edge after rst deasserts. For N=0 it rises on the first edge.
- All stall, flush and redirect outputs are combinational, same-cycle from inputs and state. Zero latency is required so the interlock acts before the next edge.
- A load-use bubble costs exactly 1 cycle.
- A taken branch costs 2 bubbles (IF/ID and ID/EX flushed).
- An M-cycle mul/div (md_done in its M-th EX cycle) holds the front end for M-1 cycles and inserts M-1 EX/MEM bubbles.
- mem_stall_req overrides MD_WAIT, branch and load-use without losing them: the frozen pipeline re-presents the same EX/ID contents once the stall drops.

## Test plan
- Reset release, BOOT_DELAY=4 -> pc_stall=1 and work_ena=0 for edges 1-4; work_ena=1 after edge 5; stall_cycles stays 0.
- Load to x5 in EX, ID reads rs2=x5 with id_rs2_use=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Same case with ex_rd=0 -> no stall.
- ex_branch_taken=1, target 0x0000_0100 -> pc_redirect=1, pc_target=0x100, if_id_flush=1, id_ex_flush=1 for one cycle.
- ex_md_start, md_done on the 4th cycle -> 3 cycles of front-end stall with ex_mem_flush, then RUN; stall_cycles += 3.
- mem_stall_req held 2 cycles during MD_WAIT with md_done=1 in the first -> all stalls for 2 cycles; MD_WAIT exits only on the cycle after mem_stall_req drops, and md_done must be held.
- rst pulsed low while in MD_WAIT -> immediate BOOT, work_ena=0, stall_cycles=0.
